// File: rtl/sram_bus_bridge.sv
// Bridges an asynchronous 6116-style SRAM pin bus onto a synchronous single-port memory IP:
// synchronised strobes, timed reads with configurable IP latency, trailing-edge write commit.
module sram_bus_bridge #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] D,
    input  logic [ADDR_W-1:0] A,
    input  logic              CS_b,
    input  logic              WE_b,
    input  logic              OE_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(READ_LAT + 1) + 1;

    typedef enum logic [1:0] {StIdle, StRdWait, StRdDrive, StWrActive} state_e;
    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, we_sync, oe_sync;
    logic [ADDR_W-1:0]      a_sync [SYNC_STAGES];
    logic [DATA_W-1:0]      d_sync [SYNC_STAGES];

    logic              cs, we, oe;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              wr_req, rd_req, rd_done, drive;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, wdata_d;
    logic [ADDR_W-1:0] addr_d;
    logic              en_d, we_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync <= '1;
            we_sync <= '1;
            oe_sync <= '1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                a_sync[i] <= '0;
                d_sync[i] <= '0;
            end
        end else begin
            cs_sync[0] <= CS_b;
            we_sync[0] <= WE_b;
            oe_sync[0] <= OE_b;
            a_sync[0]  <= A;
            d_sync[0]  <= D;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                cs_sync[i] <= cs_sync[i-1];
                we_sync[i] <= we_sync[i-1];
                oe_sync[i] <= oe_sync[i-1];
                a_sync[i]  <= a_sync[i-1];
                d_sync[i]  <= d_sync[i-1];
            end
        end
    end

    assign cs = ~cs_sync[SYNC_STAGES-1];
    assign we = ~we_sync[SYNC_STAGES-1];
    assign oe = ~oe_sync[SYNC_STAGES-1];
    assign a  = a_sync[SYNC_STAGES-1];
    assign d  = d_sync[SYNC_STAGES-1];

    // A write strobe wins over output enable, as on the real chip.
    assign wr_req  = cs & we;
    assign rd_req  = cs & oe & ~we;
    assign rd_done = (cnt_q == CNT_W'(READ_LAT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (wr_req)      state_d = StWrActive;
                else if (rd_req) state_d = StRdWait;
            end
            StRdWait: begin
                if (wr_req)       state_d = StWrActive;
                else if (!rd_req) state_d = StIdle;
                else if (rd_done) state_d = StRdDrive;
            end
            StRdDrive: begin
                if (wr_req)               state_d = StWrActive;
                else if (!rd_req)         state_d = StIdle;
                else if (a != mem_addr)   state_d = StRdWait;
            end
            StWrActive: begin
                if (!wr_req) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        // Address/data track the bus while the write strobe is held; the deassert
        // cycle itself is never captured, so the commit uses the last held values.
        if (wr_req) begin
            addr_d  = a;
            wdata_d = d;
        end
        case (state_q)
            StIdle: begin
                if (rd_req) begin
                    addr_d = a;
                    en_d   = 1'b1;
                    cnt_d  = '0;
                end
            end
            StRdWait: begin
                if (rd_req) begin
                    cnt_d = cnt_q + 1'b1;
                    if (rd_done) rdata_d = mem_rdata;
                end
            end
            StRdDrive: begin
                if (rd_req && (a != mem_addr)) begin
                    addr_d = a;
                    en_d   = 1'b1;
                    cnt_d  = '0;
                end
            end
            StWrActive: begin
                if (!wr_req) we_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            mem_en    <= en_d;
            mem_we    <= we_d;
        end
    end

    assign busy  = (state_q != StIdle);
    assign drive = (state_q == StRdDrive) && rd_req && !rst;
    assign D     = drive ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Self-checking bench for sram_bus_bridge: vector table, corner sequences, random traffic
// checked against a byte-array memory model, plus a wide/slow parameter instance.
module tb_sram_bus_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [10:0] a;
    logic        cs_b, we_b, oe_b, tb_d_en;
    logic [7:0]  tb_d;
    wire  [7:0]  d_bus;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy;
    assign d_bus = tb_d_en ? tb_d : 8'hzz;

    logic [10:0] a2;
    logic        cs2_b, we2_b, oe2_b;
    wire  [15:0] d2_bus;
    logic [10:0] mem2_addr;
    logic [15:0] mem2_wdata, mem2_rdata;
    logic        mem2_en, mem2_we, busy2;

    wire d_float  = (d_bus === 8'hzz);
    wire d2_float = (d2_bus === 16'hzzzz);

    sram_bus_bridge dut (
        .clk(clk), .rst(rst), .D(d_bus), .A(a), .CS_b(cs_b), .WE_b(we_b), .OE_b(oe_b),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .busy(busy)
    );

    sram_bus_bridge #(.DATA_W(16), .ADDR_W(11), .READ_LAT(3), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .rst(rst), .D(d2_bus), .A(a2), .CS_b(cs2_b), .WE_b(we2_b), .OE_b(oe2_b),
        .mem_addr(mem2_addr), .mem_wdata(mem2_wdata), .mem_rdata(mem2_rdata),
        .mem_en(mem2_en), .mem_we(mem2_we), .busy(busy2)
    );

    // Memory IPs: latency 1 (8-bit) and latency 3 (16-bit).
    logic [7:0]  mem0 [2048];
    logic [15:0] mem1 [2048];
    logic [15:0] p1, p2;
    logic        mem_init, pl_we, pl_sel;
    logic [10:0] pl_addr;
    logic [15:0] pl_data;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) begin
                mem0[i] <= 8'(i) ^ 8'h5A;
                mem1[i] <= 16'(i) ^ 16'h5A5A;
            end
        end
        if (pl_we && !pl_sel) mem0[pl_addr] <= pl_data[7:0];
        if (pl_we && pl_sel)  mem1[pl_addr] <= pl_data;
        if (mem_we) mem0[mem_addr] <= mem_wdata;
        if (mem_en) mem_rdata <= mem0[mem_addr];
        if (mem2_we) mem1[mem2_addr] <= mem2_wdata;
        if (mem2_en) p1 <= mem1[mem2_addr];
        p2 <= p1;
        mem2_rdata <= p2;
    end

    int          en_cnt = 0, we_cnt = 0, en_dbl = 0, we_dbl = 0, overlap = 0;
    logic        prev_en = 1'b0, prev_we = 1'b0;
    logic [10:0] en_addr = '0, we_addr = '0;
    logic [7:0]  we_data = '0;
    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt++;
            en_addr = mem_addr;
            if (prev_en) en_dbl++;
        end
        if (mem_we) begin
            we_cnt++;
            we_addr = mem_addr;
            we_data = mem_wdata;
            if (prev_we) we_dbl++;
        end
        if (mem_en && mem_we) overlap++;
        prev_en = mem_en;
        prev_we = mem_we;
    end

    int         checks = 0, errors = 0;
    logic [7:0] ref_mem [2048];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_txn(input logic [10:0] addr, input logic [7:0] exp);
        int first = -1, en_at = -1, uns = 0, e0 = en_cnt, w0 = we_cnt;
        logic [7:0] got = '0;
        a = addr; cs_b = 1'b0; oe_b = 1'b0; we_b = 1'b1; tb_d_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (mem_en && en_at < 0) en_at = k;
            if (!d_float) begin
                if (first < 0) begin
                    first = k;
                    got = d_bus;
                end else if (d_bus !== got) begin
                    uns++;
                end
            end
        end
        cs_b = 1'b1; oe_b = 1'b1;
        check("rd_data", 32'(got), 32'(exp));
        check("rd_first_valid_cycle", first, 4);
        check("rd_stable", uns, 0);
        check("rd_en_cycle", en_at, 2);
        tick; tick;
        check("rd_release", 32'(d_float), 1);
        tick;
        check("rd_idle_busy", 32'(busy), 0);
        check("rd_en_count", en_cnt - e0, 1);
        check("rd_en_addr", 32'(en_addr), 32'(addr));
        check("rd_no_we", we_cnt - w0, 0);
    endtask

    task automatic write_txn(input logic [10:0] addr, input logic [7:0] data, input int hold);
        int e0 = en_cnt, w0 = we_cnt, wk = -1;
        a = addr; tb_d = data; tb_d_en = 1'b1; cs_b = 1'b0; we_b = 1'b0; oe_b = 1'b1;
        repeat (hold) tick;
        // Bus values change with the trailing edge; the bridge must keep the held ones.
        cs_b = 1'b1; we_b = 1'b1; a = ~addr; tb_d = ~data;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (mem_we && wk < 0) wk = k;
        end
        tb_d_en = 1'b0;
        check("wr_we_cycle", wk, 2);
        check("wr_we_count", we_cnt - w0, 1);
        check("wr_no_en", en_cnt - e0, 0);
        check("wr_addr", 32'(we_addr), 32'(addr));
        check("wr_data", 32'(we_data), 32'(data));
        check("wr_idle_busy", 32'(busy), 0);
        ref_mem[addr] = data;
    endtask

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [7:0]  data;   // write data, or expected read data
        int          hold;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   drv, e0, w0, n_en, r, first, en_at;
        logic vd;
        logic [7:0]  v;
        logic [15:0] got2;
        vecs[0] = '{1'b1, 11'h7FF, 8'h3C, 5};
        vecs[1] = '{1'b0, 11'h7FF, 8'h3C, 0};
        vecs[2] = '{1'b0, 11'h123, 8'hA5, 0};
        vecs[3] = '{1'b0, 11'h045, 8'h1F, 0};
        vecs[4] = '{1'b1, 11'h000, 8'h81, 1};
        vecs[5] = '{1'b0, 11'h000, 8'h81, 0};
        vecs[6] = '{1'b1, 11'h123, 8'h11, 3};
        vecs[7] = '{1'b0, 11'h123, 8'h11, 0};

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        a = '0; cs_b = 1'b1; we_b = 1'b1; oe_b = 1'b1; tb_d = '0; tb_d_en = 1'b0;
        a2 = '0; cs2_b = 1'b1; we2_b = 1'b1; oe2_b = 1'b1;
        pl_we = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_data = '0;
        rst = 1'b1; mem_init = 1'b1;
        repeat (3) tick;
        mem_init = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", 32'(mem_wdata), 0);
        check("rst_d_released", 32'(d_float), 1);
        rst = 1'b0;
        pl_we = 1'b1; pl_sel = 1'b0; pl_addr = 11'h123; pl_data = 16'h00A5;
        tick;
        pl_sel = 1'b1; pl_data = 16'hA5C3;
        tick;
        pl_we = 1'b0;
        ref_mem[11'h123] = 8'hA5;
        tick;

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) write_txn(vecs[i].addr, vecs[i].data, vecs[i].hold);
            else            read_txn(vecs[i].addr, vecs[i].data);
        end

        // Reset while driving read data.
        a = 11'h123; cs_b = 1'b0; oe_b = 1'b0;
        repeat (6) tick;
        check("mid_read_driving", 32'(d_float), 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_d", 32'(d_float), 1);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_en", 32'(mem_en), 0);
        check("async_rst_we", 32'(mem_we), 0);
        cs_b = 1'b1; oe_b = 1'b1;
        tick; tick;
        rst = 1'b0;
        tick;

        // Abort a read before data is valid.
        e0 = en_cnt; drv = 0;
        a = 11'h010; cs_b = 1'b0; oe_b = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) cs_b = 1'b1;
            tick;
            if (!d_float) drv++;
        end
        oe_b = 1'b1;
        check("abort_never_driven", drv, 0);
        check("abort_en_count", en_cnt - e0, 1);
        check("abort_idle", 32'(busy), 0);

        // Address change during the drive phase re-issues the read.
        e0 = en_cnt; n_en = 0; r = -1; v = '0; vd = 1'b0;
        a = 11'h001; cs_b = 1'b0; oe_b = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick;
            if (mem_en) begin
                n_en++;
                if (n_en == 2) r = k;
            end
            if (r >= 0 && k == r + 2) begin
                v = d_bus;
                vd = !d_float;
            end
            if (k == 6) a = 11'h002;
        end
        cs_b = 1'b1; oe_b = 1'b1;
        repeat (4) tick;
        check("achg_en_count", en_cnt - e0, 2);
        check("achg_en_addr", 32'(en_addr), 32'h002);
        check("achg_driven", 32'(vd), 1);
        check("achg_data", 32'(v), 32'(ref_mem[11'h002]));

        // OE_b and WE_b low together: write only, bus never driven by the bridge.
        e0 = en_cnt; w0 = we_cnt; drv = 0;
        a = 11'h200; cs_b = 1'b0; oe_b = 1'b0; we_b = 1'b0; tb_d_en = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 6) begin
                cs_b = 1'b1; oe_b = 1'b1; we_b = 1'b1;
            end
            tick;
            if (!d_float) drv++;
        end
        check("prio_never_driven", drv, 0);
        check("prio_we_count", we_cnt - w0, 1);
        check("prio_no_en", en_cnt - e0, 0);
        write_txn(11'h200, 8'h99, 2);

        // Wide, slow instance: D valid at cycle 7.
        first = -1; en_at = -1; got2 = '0;
        a2 = 11'h123; cs2_b = 1'b0; oe2_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (mem2_en && en_at < 0) en_at = k;
            if (!d2_float && first < 0) begin
                first = k;
                got2 = d2_bus;
            end
        end
        cs2_b = 1'b1; oe2_b = 1'b1;
        repeat (5) tick;
        check("p2_en_cycle", en_at, 3);
        check("p2_first_valid_cycle", first, 7);
        check("p2_data", 32'(got2), 32'h0000A5C3);
        check("p2_release", 32'(d2_float), 1);
        check("p2_idle", 32'(busy2), 0);

        // Random traffic against the byte-array model.
        for (int t = 0; t < 80; t++) begin
            logic [10:0] ra;
            ra = 11'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                write_txn(ra, 8'($urandom), int'($urandom_range(1, 4)));
            else
                read_txn(ra, ref_mem[ra]);
            repeat ($urandom_range(0, 2)) tick;
        end

        check("pulse_en_single", en_dbl, 0);
        check("pulse_we_single", we_dbl, 0);
        check("pulse_no_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
